// File: rtl/fft_reorder_32.sv
// Bit-reversed to natural-order reorder buffer for a 32-point FFT, ping-pong banks.
// Optional oFrame_Start output enabled by defining FFT_REORDER_FRAME_FLAG_EN.
module fft_reorder_32 (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEn,
  input  logic [33:0] iData_Re,
  input  logic [33:0] iData_Im,
  output logic        oValid,
  output logic [33:0] oData_Re,
  output logic [33:0] oData_Im
`ifdef FFT_REORDER_FRAME_FLAG_EN
  ,
  output logic        oFrame_Start
`endif
);

  logic [67:0] mem [2][32];
  logic [4:0]  wr_cnt_q;
  logic        wr_bank_q;
  logic        primed_q;
  logic [4:0]  rd_addr;
  logic [67:0] rd_data;

  // The write bank is always the opposite of the read bank, so both ports run freely.
  always_comb begin
    rd_addr = {wr_cnt_q[0], wr_cnt_q[1], wr_cnt_q[2], wr_cnt_q[3], wr_cnt_q[4]};
    rd_data = mem[~wr_bank_q][rd_addr];
  end

  // Storage is deliberately not reset; primed_q gates every read instead.
  always_ff @(posedge iClk) begin
    if (!iRst && iEn) begin
      mem[wr_bank_q][wr_cnt_q] <= {iData_Re, iData_Im};
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_cnt_q     <= 5'd0;
      wr_bank_q    <= 1'b0;
      primed_q     <= 1'b0;
      oValid       <= 1'b0;
      oData_Re     <= 34'd0;
      oData_Im     <= 34'd0;
`ifdef FFT_REORDER_FRAME_FLAG_EN
      oFrame_Start <= 1'b0;
`endif
    end else begin
      oValid       <= iEn && primed_q;
`ifdef FFT_REORDER_FRAME_FLAG_EN
      oFrame_Start <= iEn && primed_q && (wr_cnt_q == 5'd0);
`endif
      if (iEn) begin
        wr_cnt_q <= wr_cnt_q + 5'd1;
        if (wr_cnt_q == 5'd31) begin
          wr_bank_q <= ~wr_bank_q;
          primed_q  <= 1'b1;
        end
        if (primed_q) begin
          oData_Re <= rd_data[67:34];
          oData_Im <= rd_data[33:0];
        end
      end
    end
  end

endmodule

// File: doc/fft_reorder_32.md
FFT_REORDER_32 -- requirements
Module: fft_reorder_32

Interface
REQ-001 SHALL have port iClk, input, 1 bit: single clock; all logic on rising edge.
REQ-002 SHALL have port iRst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port iEn, input, 1 bit: input sample valid; one sample accepted per cycle with iEn=1.
REQ-004 SHALL have port iData_Re, input, 34 bits: real part of FFT output sample, two's complement, bit-reversed frame order.
REQ-005 SHALL have port iData_Im, input, 34 bits: imaginary part, same format.
REQ-006 SHALL have port oValid, output, 1 bit: oData_Re/oData_Im hold a valid natural-order sample this cycle.
REQ-007 SHALL have port oData_Re, output, 34 bits: real part, natural frequency order.
REQ-008 SHALL have port oData_Im, output, 34 bits: imaginary part, natural frequency order.
REQ-009 SHALL have port oFrame_Start, output, 1 bit: present only per REQ-027; marks bin 0 of each output frame.

Function
REQ-010 SHALL store samples in two ping-pong banks, each 32 entries x 68 bits, packed {Re, Im}.
REQ-011 SHALL keep a 5-bit write counter wr_cnt and a 1-bit bank select wr_bank; on iEn=1 write the input to bank[wr_bank][wr_cnt], then increment wr_cnt.
REQ-012 SHALL, when wr_cnt wraps 31->0 on an accepted sample, toggle wr_bank and set a primed flag.
REQ-013 SHALL, on each iEn=1 cycle with primed=1, read bank[~wr_bank] at address bitrev5(wr_cnt) (bit 0<->4, 1<->3, 2 fixed).
REQ-014 SHALL register read data into oData_Re/oData_Im and assert oValid exactly one cycle after the iEn cycle that performed the read.
REQ-015 SHALL deassert oValid on any cycle following an iEn=0 cycle; oData_Re/oData_Im hold their last values.
REQ-016 SHALL keep oValid=0 throughout the first 32 accepted samples after reset (primed=0).
REQ-017 SHALL allow write and read in the same cycle without conflict, since they always target opposite banks.
REQ-018 SHALL produce, for input frame f, natural-order output bins 0..31 during the 32 accepted samples of frame f+1; output rate follows input rate, gaps in iEn propagate as gaps in oValid.
REQ-019 SHALL perform no arithmetic; data passes bit-exact, 34 bits per component.
REQ-020 SHALL, when iEn=0, hold wr_cnt, wr_bank and primed unchanged.

Reset
REQ-021 SHALL on iRst=1 at a rising edge clear wr_cnt=0, wr_bank=0, primed=0, oValid=0, oData_Re=0, oData_Im=0, oFrame_Start=0.
REQ-022 SHALL give iRst priority over iEn; a sample presented with iRst=1 is discarded.
REQ-023 SHALL not reset bank memory contents.
REQ-024 SHALL, on reset mid-frame, discard the partial frame and any unread frame; no oValid until 32 new samples have been accepted.

Configuration
REQ-025 SHALL use macro FFT_REORDER_FRAME_FLAG_EN to include or exclude oFrame_Start.
REQ-026 SHALL, without the macro, omit port oFrame_Start and its register; all other behaviour unchanged.
REQ-027 SHALL, with the macro, provide oFrame_Start asserted together with oValid exactly when the output sample is bin 0 (read issued with wr_cnt=0), else 0.

Verification
REQ-028 SHALL cover: reset, then 32 samples with Re=k,Im=-k (k=0..31, fed in bitrev5(k) position order), then 32 more -> oValid=0 for first 32; then oData_Re=0,1,2..31 in order, oValid one cycle after each iEn.
REQ-029 SHALL cover: continuous 4 frames with iEn=1 -> 96 consecutive oValid cycles, each frame natural-ordered, no bank mixing.
REQ-030 SHALL cover: second frame with iEn toggling 1,0,1,0 -> oValid follows one cycle later with matching gaps; data order unchanged.
REQ-031 SHALL cover: iRst pulsed after 20 samples of frame 2 -> oValid=0 until 32 fresh samples accepted; no old-frame data ever emitted.
REQ-032 SHALL cover: iRst=1 and iEn=1 same cycle with Re=0x3FFFFFFFF -> sample discarded, wr_cnt=0 after edge.
REQ-033 SHALL cover: with FFT_REORDER_FRAME_FLAG_EN defined, 3 frames -> oFrame_Start=1 on exactly the first oValid cycle of frames 2 and 3; without macro, build has no oFrame_Start port.
